// File: rtl/block_broadcast.sv
// Feeds the Stripe array: buffers tagged A/B operand blocks in two small FIFOs
// and broadcasts matched pairs on the shared tag/data bus under a start/beats run.

module BroadcastFifo #(
  parameter int width = 140,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [width-1:0] data_i,
  input  logic             pop_i,
  output logic             ready_o,
  output logic             empty_o,
  output logic [width-1:0] head_o
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [width-1:0] mem_q [depth];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             full;
  logic             push;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign ready_o = ~full & ~flush_i & ~rst;
  assign push    = valid_i & ready_o;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push)  wptr_q <= wptr_q + PTR_ONE;
      if (pop_i) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

module block_broadcast #(
  parameter int block_width = 128,
  parameter int tag_width   = 12,
  parameter int fifo_depth  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [tag_width-1:0]   a_tag,
  input  logic [block_width-1:0] a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [tag_width-1:0]   b_tag,
  input  logic [block_width-1:0] b_data,
  input  logic                   start,
  input  logic [tag_width-1:0]   beats,
  input  logic                   flush,
  input  logic                   bus_hold,
  output logic                   bus_valid,
  output logic [tag_width-1:0]   tagA_OUT,
  output logic [tag_width-1:0]   tagB_OUT,
  output logic [block_width-1:0] d0_OUT,
  output logic [block_width-1:0] d1_OUT,
  output logic                   busy,
  output logic                   done,
  output logic [tag_width-1:0]   bcast_count
);

  localparam int EW = tag_width + block_width;
  localparam logic [tag_width-1:0] TAG_ONE = {{(tag_width-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [tag_width-1:0]   beats_q, beats_d;
  logic [tag_width-1:0]   count_q, count_d;
  logic                   valid_q;
  logic [tag_width-1:0]   tagA_q, tagB_q;
  logic [block_width-1:0] d0_q, d1_q;
  logic                   emptyA, emptyB;
  logic [EW-1:0]          headA, headB;
  logic                   fire;

  BroadcastFifo #(.width(EW), .depth(fifo_depth)) fifoA (
    .clk(clk), .rst(rst), .flush_i(flush), .valid_i(a_valid), .data_i({a_tag, a_data}),
    .pop_i(fire), .ready_o(a_ready), .empty_o(emptyA), .head_o(headA)
  );

  BroadcastFifo #(.width(EW), .depth(fifo_depth)) fifoB (
    .clk(clk), .rst(rst), .flush_i(flush), .valid_i(b_valid), .data_i({b_tag, b_data}),
    .pop_i(fire), .ready_o(b_ready), .empty_o(emptyB), .head_o(headB)
  );

  assign fire = (state_q == RUN) & ~emptyA & ~emptyB & ~bus_hold & ~flush;

  // Flush wins over everything; the last fire of a run moves straight to DONE.
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    count_d = count_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          count_d = '0;
          if (beats == '0) begin
            state_d = DONE;
          end else begin
            beats_d = beats;
            state_d = RUN;
          end
        end
        RUN: if (fire) begin
          count_d = count_q + TAG_ONE;
          if (count_q == beats_q - TAG_ONE) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beats_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      count_q <= count_d;
    end
  end

  // Bus registers only change on fire so Stripes can keep sampling a stable pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tagA_q  <= '0;
      tagB_q  <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      valid_q <= fire;
      if (fire) begin
        {tagA_q, d0_q} <= headA;
        {tagB_q, d1_q} <= headB;
      end
    end
  end

  assign bus_valid   = valid_q;
  assign tagA_OUT    = tagA_q;
  assign tagB_OUT    = tagB_q;
  assign d0_OUT      = d0_q;
  assign d1_OUT      = d1_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign bcast_count = count_q;

endmodule

// File: tb/tb_block_broadcast.sv
// Randomized bench for block_broadcast: a queue-based transaction model predicts
// every bus output and ready flag cycle by cycle.

module tb_block_broadcast;

  localparam int TW    = 12;
  localparam int BW    = 128;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [TW-1:0] a_tag, b_tag, beats;
  logic [BW-1:0] a_data, b_data;
  logic          start, flush, bus_hold;
  logic          bus_valid, busy, done;
  logic [TW-1:0] tagA_OUT, tagB_OUT, bcast_count;
  logic [BW-1:0] d0_OUT, d1_OUT;

  block_broadcast #(.block_width(BW), .tag_width(TW), .fifo_depth(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_tag(a_tag), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_tag(b_tag), .b_data(b_data),
    .start(start), .beats(beats), .flush(flush), .bus_hold(bus_hold),
    .bus_valid(bus_valid), .tagA_OUT(tagA_OUT), .tagB_OUT(tagB_OUT),
    .d0_OUT(d0_OUT), .d1_OUT(d1_OUT), .busy(busy), .done(done),
    .bcast_count(bcast_count)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  // Model: queued blocks per stream, plus run bookkeeping.
  logic [TW+BW-1:0] qA[$];
  logic [TW+BW-1:0] qB[$];
  bit               running, donePend;
  int               target, sent;
  logic             eValid;
  logic [TW-1:0]    eTagA, eTagB;
  logic [BW-1:0]    eD0, eD1;

  task automatic checkOutput(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("bus_valid", BW'(bus_valid), BW'(eValid));
    checkOutput("tagA", BW'(tagA_OUT), BW'(eTagA));
    checkOutput("tagB", BW'(tagB_OUT), BW'(eTagB));
    checkOutput("d0", d0_OUT, eD0);
    checkOutput("d1", d1_OUT, eD1);
    checkOutput("busy", BW'(busy), BW'(running));
    checkOutput("done", BW'(done), BW'(donePend));
    checkOutput("bcast_count", BW'(bcast_count), BW'(TW'(sent)));
  endtask

  task automatic modelReset();
    qA.delete();
    qB.delete();
    running  = 1'b0;
    donePend = 1'b0;
    target   = 0;
    sent     = 0;
    eValid   = 1'b0;
    eTagA    = '0;
    eTagB    = '0;
    eD0      = '0;
    eD1      = '0;
  endtask

  task automatic clearInputs();
    a_valid = 0; a_tag = '0; a_data = '0;
    b_valid = 0; b_tag = '0; b_data = '0;
    start = 0; beats = '0; flush = 0; bus_hold = 0;
  endtask

  function automatic logic [BW-1:0] laneData(input logic [TW-1:0] t);
    return {8{{4'd0, t}}};
  endfunction

  function automatic logic [BW-1:0] randData();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic applyStimulus(input bit va, input logic [TW-1:0] ta, input logic [BW-1:0] da,
                               input bit vb, input logic [TW-1:0] tb, input logic [BW-1:0] db,
                               input bit st, input logic [TW-1:0] bt, input bit fl, input bit hd);
    bit rdyA, rdyB, fire, wasIdle, newDone;
    logic [TW+BW-1:0] e;
    @(negedge clk);
    a_valid = va; a_tag = ta; a_data = da;
    b_valid = vb; b_tag = tb; b_data = db;
    start = st; beats = bt; flush = fl; bus_hold = hd;
    #1;
    rdyA = !fl && (qA.size() < DEPTH);
    rdyB = !fl && (qB.size() < DEPTH);
    checkOutput("a_ready", BW'(a_ready), BW'(rdyA));
    checkOutput("b_ready", BW'(b_ready), BW'(rdyB));
    @(posedge clk);
    wasIdle = !running && !donePend;
    fire    = running && !fl && !hd && qA.size() > 0 && qB.size() > 0;
    newDone = 1'b0;
    if (fl) begin
      qA.delete();
      qB.delete();
      running = 1'b0;
    end else if (wasIdle && st) begin
      sent = 0;
      if (bt == 0) newDone = 1'b1;
      else begin
        running = 1'b1;
        target  = int'(bt);
      end
    end else if (fire) begin
      e = qA.pop_front();
      eTagA = e[TW+BW-1:BW];
      eD0   = e[BW-1:0];
      e = qB.pop_front();
      eTagB = e[TW+BW-1:BW];
      eD1   = e[BW-1:0];
      sent++;
      if (sent == target) begin
        running = 1'b0;
        newDone = 1'b1;
      end
    end
    donePend = newDone;
    eValid   = fire;
    if (va && rdyA) qA.push_back({ta, da});
    if (vb && rdyB) qB.push_back({tb, db});
    #1;
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, '0, '0, 0, '0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    modelReset();
    #12;
    checkOutput("a_ready_in_reset", BW'(a_ready), '0);
    checkOutput("b_ready_in_reset", BW'(b_ready), '0);
    checkAll();
    @(negedge clk);
    rst = 1'b0;

    // Three matched pairs, tags 1..3 against 7..9.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, TW'(1 + i), laneData(TW'(1 + i)), 1, TW'(7 + i), laneData(TW'(7 + i)),
                    i == 0, 12'd3, 0, 0);
    idleCycles(4);

    // Fill A past capacity, then start a run and feed one B block.
    for (int i = 0; i < 5; i++)
      applyStimulus(1, TW'(10 + i), laneData(TW'(10 + i)), 0, '0, '0, 0, '0, 0, 0);
    applyStimulus(0, '0, '0, 1, 12'd20, laneData(12'd20), 1, 12'd2, 0, 0);
    idleCycles(3);
    applyStimulus(0, '0, '0, 0, '0, '0, 0, '0, 1, 0);
    idleCycles(2);

    // Zero-beat run.
    applyStimulus(0, '0, '0, 0, '0, '0, 1, 12'd0, 0, 0);
    idleCycles(3);

    // Four beats with a two-cycle downstream stall.
    for (int i = 0; i < 8; i++)
      applyStimulus(i < 4, TW'(30 + i), randData(), i < 4, TW'(40 + i), randData(),
                    i == 0, 12'd4, 0, (i == 2) || (i == 3));
    idleCycles(2);

    // Flush after two of five beats.
    for (int i = 0; i < 6; i++)
      applyStimulus(i < 5, TW'(50 + i), randData(), i < 5, TW'(60 + i), randData(),
                    i == 0, 12'd5, i == 3, 0);
    idleCycles(2);

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      applyStimulus($urandom_range(0, 9) < 6, TW'($urandom()), randData(),
                    $urandom_range(0, 9) < 6, TW'($urandom()), randData(),
                    $urandom_range(0, 5) == 0, TW'($urandom_range(0, 5)),
                    $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0);

    // Asynchronous reset in the middle of a run.
    idleCycles(8);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, TW'(70 + i), randData(), 1, TW'(80 + i), randData(), i == 0, 12'd5, 0, 0);
    #2;
    rst = 1'b1;
    clearInputs();
    modelReset();
    #1;
    checkOutput("a_ready_async_rst", BW'(a_ready), '0);
    checkAll();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1, 12'd90, randData(), 1, 12'd91, randData(), 1, 12'd1, 0, 0);
    idleCycles(4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
